// File: rtl/hpdmc_wrseq.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_wrseq
// Description : HPDMC DDR PHY write-data sequencer. It accepts a write-burst
//               strobe, waits the write latency, then streams burst beats into
//               the D0/D1 inputs of the DQ/DM output-DDR banks. Around the
//               burst it drives the DQ/DQS tristate enables and the DQS toggle,
//               covering preamble and postamble, and it holds off new bursts
//               until write recovery has elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_wrseq #(
    parameter int DDRBITS     = 32,
    parameter int WR_LAT      = 2,
    parameter int BURST_BEATS = 4,
    parameter int TWR         = 2
) (
    input  logic                     sys_clk,
    input  logic                     sdram_rst,
    input  logic                     write,
    output logic                     ready,
    input  logic                     wdata_valid,
    input  logic [2*DDRBITS-1:0]     wdata,
    input  logic [2*DDRBITS/8-1:0]   wmask,
    output logic                     wdata_ack,
    output logic [DDRBITS-1:0]       d0,
    output logic [DDRBITS-1:0]       d1,
    output logic [DDRBITS/8-1:0]     dm0,
    output logic [DDRBITS/8-1:0]     dm1,
    output logic                     dq_oe,
    output logic                     dqs_oe,
    output logic                     dqs_toggle,
    output logic                     underrun,
    output logic                     wr_done
);

    localparam int c_MB = DDRBITS / 8;

    // Counter reload values; a zero-length phase is skipped, so its reload
    // value is never used and wraps harmlessly.
    localparam logic [7:0] c_LAT_LOAD   = 8'(WR_LAT - 1);
    localparam logic [7:0] c_BURST_LOAD = 8'(BURST_BEATS - 1);
    localparam logic [7:0] c_TWR_LOAD   = 8'(TWR - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LAT   = 3'd1;
    localparam logic [2:0] c_PRE   = 3'd2;
    localparam logic [2:0] c_BURST = 3'd3;
    localparam logic [2:0] c_POST  = 3'd4;
    localparam logic [2:0] c_REC   = 3'd5;

    logic [2:0]           r_state;
    logic [7:0]           r_cnt;
    logic [2:0]           w_state_nxt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_to_idle;

    logic [DDRBITS-1:0]   r_d0;
    logic [DDRBITS-1:0]   r_d1;
    logic [c_MB-1:0]      r_dm0;
    logic [c_MB-1:0]      r_dm1;
    logic                 r_dq_oe;
    logic                 r_dqs_oe;
    logic                 r_dqs_toggle;
    logic                 r_underrun;
    logic                 r_wr_done;

    // Next-state and shared down-counter logic for the burst timeline.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_to_idle   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (write) begin
                    if (WR_LAT == 0) begin
                        w_state_nxt = c_PRE;
                    end else begin
                        w_state_nxt = c_LAT;
                        w_cnt_nxt   = c_LAT_LOAD;
                    end
                end
            end
            c_LAT: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = c_PRE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            c_PRE: begin
                w_state_nxt = c_BURST;
                w_cnt_nxt   = c_BURST_LOAD;
            end
            c_BURST: begin
                // DDR timing cannot stall, so the beat count advances even
                // when the source has no data.
                if (r_cnt == 8'd0) begin
                    w_state_nxt = c_POST;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            c_POST: begin
                if (TWR == 0) begin
                    w_state_nxt = c_IDLE;
                    w_to_idle   = 1'b1;
                end else begin
                    w_state_nxt = c_REC;
                    w_cnt_nxt   = c_TWR_LOAD;
                end
            end
            c_REC: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = c_IDLE;
                    w_to_idle   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and counter registers; reset abandons any burst in flight.
    always_ff @(posedge sys_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // PHY-facing outputs, registered from the current state so they line up
    // one cycle behind it with the output-DDR banks.
    always_ff @(posedge sys_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            r_d0         <= '0;
            r_d1         <= '0;
            r_dm0        <= '0;
            r_dm1        <= '0;
            r_dq_oe      <= 1'b0;
            r_dqs_oe     <= 1'b0;
            r_dqs_toggle <= 1'b0;
            r_underrun   <= 1'b0;
            r_wr_done    <= 1'b0;
        end else begin
            r_dqs_oe     <= (r_state == c_PRE) || (r_state == c_BURST) || (r_state == c_POST);
            r_dq_oe      <= (r_state == c_BURST);
            r_dqs_toggle <= (r_state == c_BURST);
            r_wr_done    <= w_to_idle;
            if (r_state == c_BURST && wdata_valid) begin
                r_d0       <= wdata[DDRBITS-1:0];
                r_d1       <= wdata[2*DDRBITS-1:DDRBITS];
                r_dm0      <= wmask[c_MB-1:0];
                r_dm1      <= wmask[2*c_MB-1:c_MB];
                r_underrun <= 1'b0;
            end else if (r_state == c_BURST) begin
                // No data for this slot: mask the whole beat so memory keeps
                // its old contents.
                r_d0       <= '0;
                r_d1       <= '0;
                r_dm0      <= '1;
                r_dm1      <= '1;
                r_underrun <= 1'b1;
            end else begin
                r_d0       <= '0;
                r_d1       <= '0;
                r_dm0      <= '0;
                r_dm1      <= '0;
                r_underrun <= 1'b0;
            end
        end
    end

    assign ready      = (r_state == c_IDLE);
    assign wdata_ack  = (r_state == c_BURST) && wdata_valid;
    assign d0         = r_d0;
    assign d1         = r_d1;
    assign dm0        = r_dm0;
    assign dm1        = r_dm1;
    assign dq_oe      = r_dq_oe;
    assign dqs_oe     = r_dqs_oe;
    assign dqs_toggle = r_dqs_toggle;
    assign underrun   = r_underrun;
    assign wr_done    = r_wr_done;

endmodule
`default_nettype wire

// File: tb/tb_hpdmc_wrseq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hpdmc_wrseq
// Description : Self-checking bench for hpdmc_wrseq. Instance A uses the
//               default parameters, instance B uses WR_LAT=0, BURST_BEATS=1,
//               TWR=0. Control outputs are checked cycle by cycle against the
//               expected timeline; burst data goes through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hpdmc_wrseq;

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  dm0;
        logic [3:0]  dm1;
        logic        ur;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_a, write_b;
    logic        wdata_valid;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        sel;

    logic        ready_a, ack_a, dq_oe_a, dqs_oe_a, tog_a, ur_a, done_a;
    logic        ready_b, ack_b, dq_oe_b, dqs_oe_b, tog_b, ur_b, done_b;
    logic [31:0] d0_a, d1_a, d0_b, d1_b;
    logic [3:0]  dm0_a, dm1_a, dm0_b, dm1_b;

    logic        w_ready, w_ack, w_dq_oe, w_dqs_oe, w_tog, w_ur, w_done;
    logic [31:0] w_d0, w_d1;
    logic [3:0]  w_dm0, w_dm1;

    int          checks   = 0;
    int          failures = 0;
    beat_t       sb[$];

    always #5 clk = ~clk;

    hpdmc_wrseq dut_a (
        .sys_clk(clk), .sdram_rst(rst), .write(write_a), .ready(ready_a),
        .wdata_valid(wdata_valid), .wdata(wdata), .wmask(wmask), .wdata_ack(ack_a),
        .d0(d0_a), .d1(d1_a), .dm0(dm0_a), .dm1(dm1_a),
        .dq_oe(dq_oe_a), .dqs_oe(dqs_oe_a), .dqs_toggle(tog_a),
        .underrun(ur_a), .wr_done(done_a)
    );

    hpdmc_wrseq #(.DDRBITS(32), .WR_LAT(0), .BURST_BEATS(1), .TWR(0)) dut_b (
        .sys_clk(clk), .sdram_rst(rst), .write(write_b), .ready(ready_b),
        .wdata_valid(wdata_valid), .wdata(wdata), .wmask(wmask), .wdata_ack(ack_b),
        .d0(d0_b), .d1(d1_b), .dm0(dm0_b), .dm1(dm1_b),
        .dq_oe(dq_oe_b), .dqs_oe(dqs_oe_b), .dqs_toggle(tog_b),
        .underrun(ur_b), .wr_done(done_b)
    );

    // Route the selected instance onto one set of observation wires.
    always_comb begin
        if (sel) begin
            w_ready = ready_b; w_ack = ack_b; w_dq_oe = dq_oe_b; w_dqs_oe = dqs_oe_b;
            w_tog = tog_b; w_ur = ur_b; w_done = done_b;
            w_d0 = d0_b; w_d1 = d1_b; w_dm0 = dm0_b; w_dm1 = dm1_b;
        end else begin
            w_ready = ready_a; w_ack = ack_a; w_dq_oe = dq_oe_a; w_dqs_oe = dqs_oe_a;
            w_tog = tog_a; w_ur = ur_a; w_done = done_a;
            w_d0 = d0_a; w_d1 = d1_a; w_dm0 = dm0_a; w_dm1 = dm1_a;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst starting at relative cycle 0 (entered at posedge+1 of that
    // cycle). Expected control windows follow from L/B/T with the write
    // accepted in cycle 0: PRE at L+1, BURST L+2..L+1+B, POST L+2+B,
    // IDLE at L+3+B+T; registered outputs lag the state by one cycle.
    task automatic run_burst(input bit s, input int L, input int B, input int T,
                             input int ncyc, input int gap_cyc, input bit spam,
                             input bit mask_on, input int rst_cyc, input bit prev_done);
        bit        wr, in_burst, valid;
        int        k;
        logic [31:0] lo, hi;
        beat_t     e, got;
        logic [5:0] exp_ctrl;
        sel = s;
        for (int c = 0; c < ncyc; c++) begin
            wr       = (c == 0) || (spam && c >= 1 && c <= L + 2 + B + T);
            in_burst = (c >= L + 2) && (c <= L + 1 + B);
            k        = c - (L + 2);
            valid    = (c != gap_cyc);
            if (in_burst) begin
                lo    = 32'h11111111 * 32'(2 * k);
                hi    = 32'h11111111 * 32'(2 * k + 1);
                wdata = {hi, lo};
                wmask = mask_on ? 8'(k * 37 + 5) : 8'h00;
            end else begin
                wdata = {$urandom, $urandom};
                wmask = 8'($urandom);
            end
            wdata_valid = valid;
            if (s) write_b = wr; else write_a = wr;
            if (in_burst && c != rst_cyc) begin
                if (valid) e = '{d0: wdata[31:0], d1: wdata[63:32], dm0: wmask[3:0], dm1: wmask[7:4], ur: 1'b0};
                else       e = '{d0: 32'h0, d1: 32'h0, dm0: 4'hF, dm1: 4'hF, ur: 1'b1};
                sb.push_back(e);
            end
            if (c == rst_cyc) rst = 1'b1;
            @(negedge clk);
            if (c == rst_cyc) begin
                chk($sformatf("rst_ctrl c%0d", c),
                    {w_ready, w_ack, w_dqs_oe, w_dq_oe, w_tog, w_done, w_ur}, 7'b1000000);
                chk($sformatf("rst_data c%0d", c), {w_d0, w_d1, w_dm0, w_dm1}, 72'h0);
                sb.delete();
                for (int j = 0; j < 12; j++) begin
                    @(posedge clk); #1;
                    rst = 1'b0;
                    write_a = 1'b0; write_b = 1'b0;
                    wdata_valid = 1'b1;
                    @(negedge clk);
                    chk($sformatf("post_rst j%0d", j), {w_ready, w_ack, w_done}, 3'b100);
                end
                @(posedge clk); #1;
                return;
            end
            exp_ctrl[5] = (c == 0) || (c >= L + 3 + B + T);
            exp_ctrl[4] = in_burst && valid;
            exp_ctrl[3] = (c >= L + 2) && (c <= L + 3 + B);
            exp_ctrl[2] = (c >= L + 3) && (c <= L + 2 + B);
            exp_ctrl[1] = exp_ctrl[2];
            exp_ctrl[0] = (c == L + 3 + B + T) || (prev_done && c == 0);
            chk($sformatf("ctrl s%0d c%0d", s, c),
                {w_ready, w_ack, w_dqs_oe, w_dq_oe, w_tog, w_done}, exp_ctrl);
            got = '{d0: w_d0, d1: w_d1, dm0: w_dm0, dm1: w_dm1, ur: w_ur};
            if (w_dq_oe) begin
                if (sb.size() == 0) begin
                    chk($sformatf("sb_underflow c%0d", c), 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("beat s%0d c%0d", s, c), got, e);
                end
            end else begin
                chk($sformatf("idle_data s%0d c%0d", s, c), got, '0);
            end
            @(posedge clk); #1;
        end
        write_a = 1'b0; write_b = 1'b0;
        chk("sb_empty", 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1; write_a = 1'b0; write_b = 1'b0; wdata_valid = 1'b0;
        wdata = '0; wmask = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a", {ready_a, ack_a, dqs_oe_a, dq_oe_a, tog_a, done_a, ur_a, d0_a, d1_a, dm0_a, dm1_a},
            {1'b1, 78'h0});
        chk("reset_b", {ready_b, ack_b, dqs_oe_b, dq_oe_b, tog_b, done_b, ur_b, d0_b, d1_b, dm0_b, dm1_b},
            {1'b1, 78'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Default burst, data always valid.
        run_burst(1'b0, 2, 4, 2, 12, -1, 1'b0, 1'b0, -1, 1'b0);
        // Underrun in cycle 6 with non-zero masks on the good beats.
        run_burst(1'b0, 2, 4, 2, 12, 6, 1'b0, 1'b1, -1, 1'b0);
        // Back-to-back: second write lands in the wr_done cycle (11).
        run_burst(1'b0, 2, 4, 2, 11, -1, 1'b0, 1'b0, -1, 1'b0);
        run_burst(1'b0, 2, 4, 2, 12, -1, 1'b0, 1'b1, -1, 1'b1);
        // Writes held high during the active burst must be ignored.
        run_burst(1'b0, 2, 4, 2, 12, -1, 1'b1, 1'b0, -1, 1'b0);
        run_burst(1'b0, 2, 4, 2, 4, -1, 1'b0, 1'b0, -1, 1'b0);
        // Minimal configuration on instance B.
        run_burst(1'b1, 0, 1, 0, 6, -1, 1'b0, 1'b1, -1, 1'b0);
        run_burst(1'b1, 0, 1, 0, 5, 2, 1'b0, 1'b0, -1, 1'b0);
        // Reset mid-burst, then a clean default burst.
        run_burst(1'b0, 2, 4, 2, 12, -1, 1'b0, 1'b0, 6, 1'b0);
        run_burst(1'b0, 2, 4, 2, 12, -1, 1'b0, 1'b0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
